param_stim_seq: RTL and testbench
=================================

# param_stim_seq

Clocked stimulus sequencer that drives three parameter-width buses (`a`, `b`, `c`) into the parameterized-port consumer stage used by the parameter-width diagnostics. Each run steps through `STEPS` deterministic value sets, holding each set for `HOLD` cycles, then signals completion. All three bus widths come from parameters, so one sequencer instance can feed any width configuration of the downstream block. It replaces hand-written `initial` assignments with a restartable, abortable sequence.

## Interface
- `A_W`, default 1: width of bus `a`; must be ≥1.
- `B_W`, default 2: width of bus `b`; must be ≥1.
- `C_W`, default 3: width of bus `c`; must be ≥1.
- `STEPS`, default 4: number of value sets per run; must be ≥1.
- `HOLD`, default 2: cycles each value set is held; must be ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `abort`  in  1  cancels an in-progress run; sampled in RUN and DONE.
- `a`  out  A_W  stimulus bus a.
- `b`  out  B_W  stimulus bus b.
- `c`  out  C_W  stimulus bus c.
- `valid`  out  1  high while `a`/`b`/`c` carry a sequence value.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse when a run completes normally.
- `aborted`  out  1  one-cycle pulse when a run is cancelled.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset:** state is IDLE. `a`, `b`, `c`, `valid`, `busy`, `done` and `aborted` are all 0. Step counter `k` and hold counter `h` are 0.
- **IDLE:**
  - Outputs are zero, `valid` is 0.
  - If `start` is 1, the next state is RUN with `k=0`, `h=0`.
- **RUN:**
  - `valid` = 1, `busy` = 1.
  - `a` = `k mod 2^A_W`.
  - `b` = `(3*k) mod 2^B_W`.
  - `c` = `(~k) mod 2^C_W`, where `~k` is the bitwise inverse of `k` zero-extended to `max(C_W, counter width)`.
- **RUN counting:**
  - `h` increments every cycle.
  - When `h == HOLD-1`, `h` goes to 0 and `k` increments.
  - When `h == HOLD-1` and `k == STEPS-1`, the next state is DONE.
- **DONE:**
  - Lasts exactly one cycle.
  - Outputs are zero, `valid` = 0, `busy` = 1, `done` = 1.
  - Next state is IDLE.
- **`abort`:**
  - In RUN or DONE, `abort` takes priority over all other transitions.
  - Next state is IDLE, outputs are zeroed, `aborted` = 1 for one cycle (registered, asserted in the first IDLE cycle), and `done` is not asserted.
  - `abort` in IDLE has no effect.
- **`start` outside IDLE:** ignored. It is not queued. `start` held high across the DONE→IDLE transition launches a new run from that IDLE cycle.
- **Mid-run reset:** `rst` wins over `abort` and `start`. It returns the block to the reset state on the next edge, with no `done` or `aborted` pulse.
- **Counter widths:**
  - `k` is `$clog2(STEPS+1)` bits.
  - `h` is `$clog2(HOLD+1)` bits.
  - No wrap occurs within a run.
  - Truncation to bus width is modulo 2^width (plain low-bit slice).

## Timing
- **Start latency:** `start` high in IDLE at edge N. From edge N, state is RUN with step 0 on the buses and `valid` = 1.
- **Hold duration:** step `k` is visible for exactly `HOLD` consecutive cycles.
- **Run length:** total RUN duration is `STEPS*HOLD` cycles. DONE follows for 1 cycle. The first IDLE cycle comes `STEPS*HOLD+1` cycles after entering RUN.
- **Registered outputs:** all outputs are registered (driven from state/counters), with no combinational path from `start` or `abort`.
- **Abort latency:** `abort` sampled at edge M. From edge M, state is IDLE, `aborted` = 1, and `valid` = 0. `aborted` returns to 0 one cycle later.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with `start` = 1 → all outputs 0 and `busy` = 0 throughout, and no run is launched until the first cycle with `rst` low.
- **Default run:** defaults, single `start` pulse → `(a,b,c)` sequence (0,0,7)×2, (1,3,6)×2, (0,2,5)×2, (1,1,4)×2, then one cycle with `done` = 1 and buses 0, then IDLE. `valid` is high for exactly 8 cycles.
- **Abort mid-run:** abort during step 2, first hold cycle → next cycle IDLE, `aborted` = 1 for 1 cycle, `done` never asserted, and buses read 0.
- **Start while busy:** `start` held high continuously → back-to-back runs separated by exactly one DONE cycle and one IDLE cycle. `start` pulses during RUN do not alter the sequence.
- **Wide, single-cycle configuration:** `A_W=2`, `B_W=6`, `C_W=3`, `STEPS=6`, `HOLD=1` → `b` = 0, 3, 6, 9, 12, 15 and `c` = 7, 6, 5, 4, 3, 2, each held for one cycle, and `done` appears in cycle 7 after entry to RUN.
- **Reset mid-run:** assert `rst` during step 1 → next cycle matches the reset state, with no `done` or `aborted` pulse. A following `start` restarts at step 0.

Source files
------------

// File: rtl/param_stim_seq_if.sv
// -----------------------------------------------------------------------------
// param_stim_seq_if
//   Bundles the control and stimulus signals between the sequencer and the
//   logic around it. The bus widths are parameters of the interface, so each
//   instance can match one width configuration of the downstream block.
//
//   start   : run request from the controller
//   abort   : cancels an in-progress run
//   a, b, c : stimulus buses (A_W, B_W, C_W bits)
//   valid   : a/b/c carry a sequence value
//   busy    : a run is in progress (RUN or DONE)
//   done    : one-cycle pulse when a run completes normally
//   aborted : one-cycle pulse when a run is cancelled
//
//   master : the sequencer side (drives stimulus and status)
//   slave  : the controller/consumer side
// -----------------------------------------------------------------------------
interface param_stim_seq_if #(
  parameter int A_W = 1,
  parameter int B_W = 2,
  parameter int C_W = 3
);
  logic           start;
  logic           abort;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic [C_W-1:0] c;
  logic           valid;
  logic           busy;
  logic           done;
  logic           aborted;

  modport master (
    input  start, abort,
    output a, b, c, valid, busy, done, aborted
  );

  modport slave (
    output start, abort,
    input  a, b, c, valid, busy, done, aborted
  );
endinterface

// File: rtl/param_stim_seq.sv
// -----------------------------------------------------------------------------
// param_stim_seq
//   Restartable, abortable stimulus sequencer for three parameter-width
//   buses. A run steps through STEPS value sets; each set is held for HOLD
//   cycles, one DONE cycle follows, and the block then returns to IDLE.
//   The values driven for step k are:
//     a = k mod 2^A_W,  b = 3k mod 2^B_W,  c = ~k mod 2^C_W
//
//   Ports:
//     clk : clock, all state changes on the rising edge
//     rst : synchronous active-high reset
//     bus : param_stim_seq_if master modport. Its A_W/B_W/C_W must match the
//           parameters of this module.
//           start (in), abort (in), a/b/c (out), valid (out), busy (out),
//           done (out), aborted (out)
//
//   Every output is decoded from registered state (FSM state, step/hold
//   counters, aborted flag). There is no combinational path from start or
//   abort to any output.
// -----------------------------------------------------------------------------
module param_stim_seq #(
  parameter int A_W   = 1,
  parameter int B_W   = 2,
  parameter int C_W   = 3,
  parameter int STEPS = 4,
  parameter int HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  param_stim_seq_if.master   bus
);

  localparam int KW = $clog2(STEPS + 1);
  localparam int HW = $clog2(HOLD + 1);

  localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_p0, state_nxt;
  logic [KW-1:0] k_p0, k_nxt;
  logic [HW-1:0] h_p0, h_nxt;
  logic          aborted_p0, aborted_nxt;

  // The bus values are plain low-bit slices of k (or of expressions on k).
  // Every operand is cast to the bus width first, so each result is already
  // taken modulo 2^width. This also gives the zero-extend-then-invert
  // behaviour for c when C_W is wider than the counter.
  function automatic logic [A_W-1:0] value_a(input logic [KW-1:0] kv);
    return A_W'(kv);
  endfunction

  function automatic logic [B_W-1:0] value_b(input logic [KW-1:0] kv);
    logic [B_W-1:0] kb;
    kb = B_W'(kv);
    return kb + (kb << 1);
  endfunction

  function automatic logic [C_W-1:0] value_c(input logic [KW-1:0] kv);
    logic [C_W-1:0] kc;
    kc = C_W'(kv);
    return ~kc;
  endfunction

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= IDLE;
      k_p0       <= '0;
      h_p0       <= '0;
      aborted_p0 <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      k_p0       <= k_nxt;
      h_p0       <= h_nxt;
      aborted_p0 <= aborted_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt   = state_p0;
    k_nxt       = k_p0;
    h_nxt       = h_p0;
    aborted_nxt = 1'b0;

    unique case (state_p0)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          k_nxt     = '0;
          h_nxt     = '0;
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_nxt   = IDLE;
          k_nxt       = '0;
          h_nxt       = '0;
          aborted_nxt = 1'b1;
        end else if (h_p0 == H_LAST) begin
          h_nxt = '0;
          if (k_p0 == K_LAST) begin
            state_nxt = DONE;
            k_nxt     = '0;
          end else begin
            k_nxt = k_p0 + KW'(1);
          end
        end else begin
          h_nxt = h_p0 + HW'(1);
        end
      end

      DONE: begin
        // An abort here still produces an aborted pulse. The done pulse has
        // already been shown during this DONE cycle.
        state_nxt   = IDLE;
        k_nxt       = '0;
        h_nxt       = '0;
        aborted_nxt = bus.abort;
      end

      default: begin
        state_nxt = IDLE;
        k_nxt     = '0;
        h_nxt     = '0;
      end
    endcase
  end

  // ---- output decode from registered state ----
  always_comb begin
    bus.a       = '0;
    bus.b       = '0;
    bus.c       = '0;
    bus.valid   = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.aborted = aborted_p0;

    unique case (state_p0)
      RUN: begin
        bus.a     = value_a(k_p0);
        bus.b     = value_b(k_p0);
        bus.c     = value_c(k_p0);
        bus.valid = 1'b1;
        bus.busy  = 1'b1;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_param_stim_seq.sv
// -----------------------------------------------------------------------------
// tb_param_stim_seq
//   Directed bench for param_stim_seq.
//   dut0 : default configuration (A_W=1, B_W=2, C_W=3, STEPS=4, HOLD=2).
//          Driven from a per-cycle vector table of {rst, start, abort} inputs
//          and the expected {a, b, c, valid, busy, done, aborted} after the
//          following rising edge.
//   dut1 : wide single-cycle configuration (A_W=2, B_W=6, C_W=3, STEPS=6,
//          HOLD=1). Checked by a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_param_stim_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  param_stim_seq_if #(.A_W(1), .B_W(2), .C_W(3)) bus0 ();
  param_stim_seq_if #(.A_W(2), .B_W(6), .C_W(3)) bus1 ();

  param_stim_seq #(.A_W(1), .B_W(2), .C_W(3), .STEPS(4), .HOLD(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  param_stim_seq #(.A_W(2), .B_W(6), .C_W(3), .STEPS(6), .HOLD(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  // Expected output packing: {a[0], b[1:0], c[2:0], valid, busy, done, aborted}
  typedef struct {
    logic       rst;
    logic       start;
    logic       abort;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input logic r, input logic s, input logic ab,
                              input logic [0:0] ea, input logic [1:0] eb,
                              input logic [2:0] ec, input logic v,
                              input logic bs, input logic d, input logic abd);
    vec_t t;
    t.rst   = r;
    t.start = s;
    t.abort = ab;
    t.exp   = {ea, eb, ec, v, bs, d, abd};
    vecs.push_back(t);
  endfunction

  // One RUN cycle of the default sequence for step k (values computed by hand).
  function automatic void add_run(input logic s, input logic ab, input int k);
    case (k)
      0:       add(1'b0, s, ab, 1'b0, 2'd0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      1:       add(1'b0, s, ab, 1'b1, 2'd3, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
      2:       add(1'b0, s, ab, 1'b0, 2'd2, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      default: add(1'b0, s, ab, 1'b1, 2'd1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    endcase
  endfunction

  task automatic check1(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  logic [9:0] got0;

  initial begin
    rst        = 1'b1;
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;

    // Reset for two cycles with start high: everything stays at zero.
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Default run, with a start pulse during RUN that must be ignored.
    add_run(1'b1, 1'b0, 0);
    add_run(1'b0, 1'b0, 0);
    add_run(1'b0, 1'b0, 1);
    add_run(1'b1, 1'b0, 1);
    add_run(1'b0, 1'b0, 2);
    add_run(1'b0, 1'b0, 2);
    add_run(1'b0, 1'b0, 3);
    add_run(1'b0, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0); // DONE
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); // IDLE
    // Start held high: run, DONE, one IDLE cycle, then the next run.
    for (int k = 0; k < 4; k++) begin
      add_run(1'b1, 1'b0, k);
      add_run(1'b1, 1'b0, k);
    end
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0); // DONE
    add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); // IDLE
    add_run(1'b1, 1'b0, 0);
    add_run(1'b0, 1'b0, 0);
    add_run(1'b0, 1'b0, 1);
    add_run(1'b0, 1'b0, 1);
    add_run(1'b0, 1'b0, 2);   // step 2, first hold cycle
    // Abort sampled here: IDLE with aborted for exactly one cycle.
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Abort in IDLE does nothing.
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset during step 1 with start and abort also high: rst wins, no pulses.
    add_run(1'b1, 1'b0, 0);
    add_run(1'b0, 1'b0, 0);
    add_run(1'b0, 1'b0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Restart from step 0, then abort while in DONE.
    for (int k = 0; k < 4; k++) begin
      add_run(k == 0, 1'b0, k);
      add_run(1'b0, 1'b0, k);
    end
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0); // DONE
    add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    foreach (vecs[i]) begin
      rst        = vecs[i].rst;
      bus0.start = vecs[i].start;
      bus0.abort = vecs[i].abort;
      @(posedge clk);
      #1;
      got0 = {bus0.a, bus0.b, bus0.c, bus0.valid, bus0.busy, bus0.done,
              bus0.aborted};
      checks++;
      if (got0 !== vecs[i].exp) begin
        failures++;
        $display("FAIL row%0d {a,b,c,valid,busy,done,aborted} got=%b exp=%b",
                 i, got0, vecs[i].exp);
      end
      @(negedge clk);
    end
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    rst        = 1'b0;

    // Wide configuration: idle after the shared reset, then one run.
    check1("wide_idle_busy", 32'(bus1.busy), 32'd0);
    check1("wide_idle_c", 32'(bus1.c), 32'd0);
    bus1.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      bus1.start = 1'b0;
      check1($sformatf("wide_a_s%0d", i), 32'(bus1.a), 32'(i % 4));
      check1($sformatf("wide_b_s%0d", i), 32'(bus1.b), 32'(3 * i));
      check1($sformatf("wide_c_s%0d", i), 32'(bus1.c), 32'(7 - i));
      check1($sformatf("wide_valid_s%0d", i), 32'(bus1.valid), 32'd1);
      check1($sformatf("wide_done_s%0d", i), 32'(bus1.done), 32'd0);
    end
    @(posedge clk);
    #1;
    check1("wide_done_c7", 32'(bus1.done), 32'd1);
    check1("wide_valid_c7", 32'(bus1.valid), 32'd0);
    check1("wide_busy_c7", 32'(bus1.busy), 32'd1);
    check1("wide_b_c7", 32'(bus1.b), 32'd0);
    @(posedge clk);
    #1;
    check1("wide_idle_done", 32'(bus1.done), 32'd0);
    check1("wide_idle_busy2", 32'(bus1.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
